phase_bank: RTL and testbench



---
 rtl/phase_pkg.sv | 40 ++++
 rtl/phase_bank_mem.sv | 52 +++++
 rtl/phase_bank.sv | 153 +++++++++++++++
 tb/tb_phase_bank.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/phase_pkg.sv
// Shared types and constants for the phase_bank slice: command word layout,
// opcode and FSM enums, and the 8-bit wrapping phase adder.
package phase_pkg;

  localparam int unsigned PHASE_W   = 8;
  localparam int unsigned ADDR_LSB  = 0;
  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned VALUE_LSB = 8;
  localparam int unsigned VALUE_W   = 8;
  localparam int unsigned OP_LSB    = 16;
  localparam int unsigned OP_W      = 2;
  localparam int unsigned CMD_W     = OP_LSB + OP_W;

  typedef enum logic [1:0] {
    OP_NOP    = 2'd0,
    OP_WRITE  = 2'd1,
    OP_COMMIT = 2'd2,
    OP_CLEAR  = 2'd3
  } phase_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMMIT = 2'd1,
    CLEAR  = 2'd2
  } phase_bank_state_e;

  // Low CMD_W bits of latest_data, MSB first: op, value, addr.
  typedef struct packed {
    phase_op_e            op;
    logic [VALUE_W-1:0]   value;
    logic [ADDR_W-1:0]    addr;
  } phase_cmd_t;

  // Phase arithmetic is modulo one full turn; the carry is discarded.
  function automatic logic [PHASE_W-1:0] phase_add(input logic [PHASE_W-1:0] a,
                                                   input logic [PHASE_W-1:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/phase_bank_mem.sv
// Shadow (and, with PHASE_BANK_CALIB_EN, calibration) storage for phase_bank:
// one synchronous write port plus a combinational sweep read port.
module phase_bank_mem
  import phase_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 256,
  parameter int unsigned IDX_W        = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               shadow_we,
`ifdef PHASE_BANK_CALIB_EN
  input  logic               calib_we,
  output logic [PHASE_W-1:0] rd_calib_c,
`endif
  input  logic               clear_we,
  input  logic [IDX_W-1:0]   wr_addr,
  input  logic [PHASE_W-1:0] wr_data,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [PHASE_W-1:0] rd_shadow_c
);

  logic [PHASE_W-1:0] shadow [NUM_CHANNELS];

  // Host writes and the clear sweep never coincide: writes are only taken in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '{default: '0};
    end else if (shadow_we) begin
      shadow[wr_addr] <= wr_data;
    end else if (clear_we) begin
      shadow[rd_idx] <= '0;
    end
  end

  assign rd_shadow_c = shadow[rd_idx];

`ifdef PHASE_BANK_CALIB_EN
  logic [PHASE_W-1:0] calib [NUM_CHANNELS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      calib <= '{default: '0};
    end else if (calib_we) begin
      calib[wr_addr] <= wr_data;
    end
  end

  assign rd_calib_c = calib[rd_idx];
`endif

endmodule

// File: rtl/phase_bank.sv
// Double-buffered per-transducer phase bank: host writes land in shadow storage,
// COMMIT sweeps them (plus calibration when PHASE_BANK_CALIB_EN is defined) into phases.
module phase_bank
  import phase_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 256
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            phase_parse_en,
  input  logic                            phase_calib_en,
  input  logic [31:0]                     latest_data,
  output logic [NUM_CHANNELS*PHASE_W-1:0] phases,
  output logic                            busy,
  output logic                            frame_valid,
  output logic                            cmd_error,
  output logic [7:0]                      drop_count
);

  localparam int unsigned IDX_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int unsigned DROP_W = 8;
  localparam int unsigned DSUM_W = DROP_W + 1;

  phase_bank_state_e  state, state_d;
  phase_cmd_t         cmd;
  logic [IDX_W-1:0]   idx;
  logic               last;
  logic               accept;
  logic               in_range;
  logic               shadow_we, clear_we, err_set;
  logic               busy_d, frame_valid_d;
  logic [1:0]         drop_n;
  logic [DSUM_W-1:0]  drop_sum;
  logic [PHASE_W-1:0] rd_shadow_c;
  logic [PHASE_W-1:0] commit_val;
  logic               unused_hi;

  assign cmd      = phase_cmd_t'(latest_data[CMD_W-1:0]);
  assign in_range = 32'(cmd.addr) < NUM_CHANNELS;
  assign last     = 32'(idx) == NUM_CHANNELS - 1;
  assign accept   = (state == IDLE);

`ifdef PHASE_BANK_CALIB_EN
  logic               calib_we;
  logic [PHASE_W-1:0] rd_calib_c;
  assign unused_hi  = ^latest_data[31:CMD_W];
  assign commit_val = phase_add(rd_shadow_c, rd_calib_c);
`else
  assign unused_hi  = ^{latest_data[31:CMD_W], phase_calib_en};
  assign commit_val = rd_shadow_c;
`endif

  phase_bank_mem #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .IDX_W        (IDX_W)
  ) u_mem (
    .clk         (clk),
    .rst         (rst),
    .shadow_we   (shadow_we),
`ifdef PHASE_BANK_CALIB_EN
    .calib_we    (calib_we),
    .rd_calib_c  (rd_calib_c),
`endif
    .clear_we    (clear_we),
    .wr_addr     (IDX_W'(cmd.addr)),
    .wr_data     (cmd.value),
    .rd_idx      (idx),
    .rd_shadow_c (rd_shadow_c)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next state: opcodes start a sweep from IDLE; a sweep ends on its last index.
  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (phase_parse_en && cmd.op == OP_COMMIT)     state_d = COMMIT;
        else if (phase_parse_en && cmd.op == OP_CLEAR) state_d = CLEAR;
      end
      COMMIT, CLEAR: begin
        if (last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobe decode, drop accounting and next values of the registered outputs.
  always_comb begin
    shadow_we     = 1'b0;
    clear_we      = (state == CLEAR);
    err_set       = 1'b0;
    drop_n        = 2'd0;
    busy_d        = (state_d != IDLE);
    frame_valid_d = (state == COMMIT) && last;
`ifdef PHASE_BANK_CALIB_EN
    calib_we      = 1'b0;
`endif
    if (accept) begin
      if (phase_parse_en) begin
        case (cmd.op)
          OP_WRITE: begin
            if (in_range) shadow_we = 1'b1;
            else          err_set   = 1'b1;
          end
          OP_NOP:  err_set = 1'b1;
          default: ;
        endcase
      end
`ifdef PHASE_BANK_CALIB_EN
      if (phase_calib_en) begin
        if (phase_parse_en) drop_n   = 2'd1;
        else if (in_range)  calib_we = 1'b1;
        else                err_set  = 1'b1;
      end
`endif
    end else begin
`ifdef PHASE_BANK_CALIB_EN
      drop_n = 2'(phase_parse_en) + 2'(phase_calib_en);
`else
      drop_n = 2'(phase_parse_en);
`endif
    end
  end

  assign drop_sum = {1'b0, drop_count} + DSUM_W'(drop_n);

  // Sweep index, status outputs and the active bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx         <= '0;
      busy        <= 1'b0;
      frame_valid <= 1'b0;
      cmd_error   <= 1'b0;
      drop_count  <= '0;
      phases      <= '0;
    end else begin
      busy        <= busy_d;
      frame_valid <= frame_valid_d;
      if (err_set) cmd_error <= 1'b1;
      drop_count  <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
      if (state != IDLE && !last) idx <= idx + IDX_W'(1);
      else                        idx <= '0;
      if (state == COMMIT)     phases[32'(idx)*PHASE_W +: PHASE_W] <= commit_val;
      else if (state == CLEAR) phases[32'(idx)*PHASE_W +: PHASE_W] <= '0;
    end
  end

endmodule

// File: tb/tb_phase_bank.sv
// Randomized self-checking bench for phase_bank against a transaction-level model
// (shadow/calib/active arrays plus sweep start time); honours PHASE_BANK_CALIB_EN.
module tb_phase_bank;

  localparam int unsigned N   = 16;
  localparam int          N_I = 16;
  localparam int unsigned W   = N * 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ph  = 1'b0;
  logic         ca  = 1'b0;
  logic [31:0]  data = '0;
  logic [W-1:0] phases;
  logic         busy, frame_valid, cmd_error;
  logic [7:0]   drop_count;

  always #5 clk = ~clk;

  phase_bank #(.NUM_CHANNELS(N)) dut (
    .clk            (clk),
    .rst            (rst),
    .phase_parse_en (ph),
    .phase_calib_en (ca),
    .latest_data    (data),
    .phases         (phases),
    .busy           (busy),
    .frame_valid    (frame_valid),
    .cmd_error      (cmd_error),
    .drop_count     (drop_count)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference model: storage contents, committed bank, and the in-flight sweep.
  int sh [N];
  int cal[N];
  int act[N];
  int tgt[N];
  int sw_start, fv_cycle, cyc, drops;
  bit err;

  function automatic bit exp_busy();
    return sw_start >= 0 && cyc >= sw_start + 1 && cyc <= sw_start + N_I;
  endfunction

  function automatic logic [W-1:0] exp_phases();
    logic [W-1:0] v;
    for (int i = 0; i < N_I; i++)
      v[i*8 +: 8] = (sw_start >= 0 && cyc >= sw_start + 2 + i) ? 8'(tgt[i]) : 8'(act[i]);
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_I; i++) begin
      sh[i] = 0; cal[i] = 0; act[i] = 0; tgt[i] = 0;
    end
    sw_start = -1; fv_cycle = -1; drops = 0; err = 1'b0;
  endtask

  task automatic model_retire();
    if (sw_start >= 0 && cyc > sw_start + N_I) begin
      for (int i = 0; i < N_I; i++) act[i] = tgt[i];
      sw_start = -1;
    end
  endtask

  task automatic add_drops(input int n);
    drops = (drops + n > 255) ? 255 : drops + n;
  endtask

  task automatic model_apply(input logic p, input logic c, input logic [31:0] d);
    int addr, val;
    addr = int'(d[7:0]);
    val  = int'(d[15:8]);
    if (exp_busy()) begin
      add_drops(int'(p));
`ifdef PHASE_BANK_CALIB_EN
      add_drops(int'(c));
`endif
    end else begin
      if (p) begin
        case (d[17:16])
          2'd0: err = 1'b1;
          2'd1: if (addr < N_I) sh[addr] = val; else err = 1'b1;
          2'd2: begin
            for (int i = 0; i < N_I; i++) tgt[i] = (sh[i] + cal[i]) % 256;
            sw_start = cyc;
            fv_cycle = cyc + N_I + 1;
          end
          default: begin
            for (int i = 0; i < N_I; i++) begin sh[i] = 0; tgt[i] = 0; end
            sw_start = cyc;
          end
        endcase
      end
`ifdef PHASE_BANK_CALIB_EN
      if (c) begin
        if (p)              add_drops(1);
        else if (addr < N_I) cal[addr] = val;
        else                err = 1'b1;
      end
`endif
    end
  endtask

  task automatic check_outputs();
    check_eq("busy",        W'(busy),        W'(exp_busy()));
    check_eq("frame_valid", W'(frame_valid), W'(cyc == fv_cycle));
    check_eq("cmd_error",   W'(cmd_error),   W'(err));
    check_eq("drop_count",  W'(drop_count),  W'(drops));
    check_eq("phases",      phases,          exp_phases());
  endtask

  // One clock: check this cycle's outputs, then drive this cycle's strobes.
  task automatic step(input logic p, input logic c, input logic [31:0] d);
    @(negedge clk);
    model_retire();
    check_outputs();
    ph = p; ca = c; data = d;
    model_apply(p, c, d);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, $urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ph = 1'b0; ca = 1'b0;
    model_reset();
    cyc++;
    @(negedge clk);
    check_outputs();
    check_eq("rst_busy",   W'(busy), '0);
    check_eq("rst_phases", phases,   '0);
    cyc++;
    rst = 1'b0;
  endtask

  function automatic logic [31:0] mk(input logic [1:0] op, input logic [7:0] addr,
                                      input logic [7:0] val);
    return {14'($urandom), op, val, addr};
  endfunction

  initial begin
    logic [1:0] op;
    logic       p, c;
    cyc = 0;
    model_reset();
    do_reset();

    // Single write then commit.
    step(1'b1, 1'b0, mk(2'd1, 8'd5, 8'h40));
    step(1'b1, 1'b0, mk(2'd2, 8'd0, 8'h00));
    idle(N_I + 2);
    check_eq("t1_ch5", W'(phases[47:40]), W'(8'h40));

    // Calibration offset with 8-bit wrap.
    step(1'b0, 1'b1, mk(2'd0, 8'd5, 8'hF0));
    step(1'b1, 1'b0, mk(2'd1, 8'd5, 8'h20));
    step(1'b1, 1'b0, mk(2'd2, 8'd0, 8'h00));
    idle(N_I + 2);
`ifdef PHASE_BANK_CALIB_EN
    check_eq("t2_ch5", W'(phases[47:40]), W'(8'h10));
`else
    check_eq("t2_ch5", W'(phases[47:40]), W'(8'h20));
`endif

    // Shadow write is invisible until commit.
    step(1'b1, 1'b0, mk(2'd1, 8'd7, 8'h11));
    idle(3);
    check_eq("t3_ch7_hold", W'(phases[63:56]), W'(8'h00));
    step(1'b1, 1'b0, mk(2'd2, 8'd0, 8'h00));
    idle(N_I + 2);
    check_eq("t3_ch7", W'(phases[63:56]), W'(8'h11));

    // Writes during a commit are dropped and counted.
    do_reset();
    step(1'b1, 1'b0, mk(2'd2, 8'd0, 8'h00));
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, mk(2'd1, 8'd1, 8'hAA));
    idle(N_I);
    check_eq("t4_drops", W'(drop_count), W'(8'd3));
    check_eq("t4_err",   W'(cmd_error),  '0);
    step(1'b1, 1'b0, mk(2'd2, 8'd0, 8'h00));
    idle(N_I + 2);
    check_eq("t4_ch1", W'(phases[15:8]), W'(8'h00));

    // Out-of-range write, NOP opcode, and same-cycle phase + calib strobes.
    step(1'b1, 1'b0, mk(2'd1, 8'(N), 8'h55));
    idle(1);
    check_eq("t5_err_range", W'(cmd_error), W'(1'b1));
    step(1'b1, 1'b0, mk(2'd0, 8'd2, 8'h66));
    step(1'b1, 1'b1, mk(2'd1, 8'd2, 8'h33));
    idle(2);
`ifdef PHASE_BANK_CALIB_EN
    check_eq("t5_drop_both", W'(drop_count), W'(8'd4));
`else
    check_eq("t5_drop_both", W'(drop_count), W'(8'd3));
`endif
    step(1'b1, 1'b0, mk(2'd2, 8'd0, 8'h00));
    idle(N_I + 2);
    check_eq("t5_ch2", W'(phases[23:16]), W'(8'h33));
    check_eq("t5_ch0", W'(phases[7:0]),   W'(8'h00));

    // Reset in the middle of a commit, then a clean commit.
    step(1'b1, 1'b0, mk(2'd1, 8'd3, 8'h77));
    step(1'b1, 1'b0, mk(2'd2, 8'd0, 8'h00));
    idle(5);
    do_reset();
    idle(N_I + 3);
    step(1'b1, 1'b0, mk(2'd1, 8'd3, 8'h5A));
    step(1'b1, 1'b0, mk(2'd2, 8'd0, 8'h00));
    idle(N_I + 2);
    check_eq("t6_ch3", W'(phases[31:24]), W'(8'h5A));

    // Drop counter saturation.
    for (int r = 0; r < 20; r++) begin
      step(1'b1, 1'b0, mk(2'd2, 8'd0, 8'h00));
      for (int k = 0; k < N_I; k++) step(1'b1, 1'b0, mk(2'd1, 8'd4, 8'h99));
    end
    idle(2);
    check_eq("t7_drop_sat", W'(drop_count), W'(8'd255));

    // Randomized traffic.
    do_reset();
    for (int k = 0; k < 800; k++) begin
      p = ($urandom_range(0, 99) < 40);
      c = ($urandom_range(0, 3) == 0);
      if (p && c && exp_busy()) c = 1'b0;
      case ($urandom_range(0, 19))
        0:       op = 2'd0;
        1:       op = 2'd2;
        2:       op = 2'd3;
        default: op = 2'd1;
      endcase
      step(p, c, mk(op, 8'($urandom_range(0, N_I + 2)), 8'($urandom)));
    end
    idle(N_I + 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
